gpio: RTL
=========

# gpio

Wishbone B4 classic slave providing general-purpose outputs, synchronized inputs and per-bit rising-edge interrupt capture. Sits downstream of `intercon` as an additional slave, sharing the slave-side `cyc/adr/dat/sel/we` bus and receiving its own `stb` line; replaces the temporary UART-to-LED path by driving `soc_leds_o` through `gpio_out_o`. Clocked and reset by the syscon outputs like every other IP core.

## Interface
- `WIDTH`, 8, number of GPIO bits per direction (1..32).
- Bus widths come from `config.v`; the block requires `DAT_WIDTH`=32 and `SEL_WIDTH`=4.

- `clk_i`  in  1  system clock (driven from `syscon_clk_o`).
- `rst_i`  in  1  reset; one clock, reset is synchronous and active-high.
- `gpio_stb_i`  in  1  strobe from intercon (slave select).
- `gpio_cyc_i`  in  1  bus cycle.
- `gpio_we_i`  in  1  write enable.
- `gpio_sel_i`  in  `SEL_WIDTH`  byte lane selects.
- `gpio_adr_i`  in  `ADR_WIDTH`  byte address; only `[4:2]` decoded, `[1:0]` ignored.
- `gpio_dat_i`  in  `DAT_WIDTH`  write data.
- `gpio_dat_o`  out  `DAT_WIDTH`  read data.
- `gpio_ack_o`  out  1  normal termination.
- `gpio_err_o`  out  1  error termination.
- `gpio_in_i`  in  `WIDTH`  asynchronous input pins.
- `gpio_out_o`  out  `WIDTH`  output pins (registered).
- `gpio_irq_o`  out  1  level interrupt (registered).

## Operation
- Register map (`adr[4:2]`): 0 OUT (RW), 1 IN (RO), 2 EDGE_EN (RW), 3 PENDING (RW1C), 4 IRQ_EN (RW); 5..7 unmapped. Bits above `WIDTH-1` read 0, writes ignored.
- Access accepted when `gpio_cyc_i & gpio_stb_i & ~gpio_ack_o & ~gpio_err_o`.
- Error: access to 5..7, or write to IN -> `gpio_err_o` instead of ack; no state change; `gpio_dat_o`=0.
- Writes honour `gpio_sel_i`: lane n updates bits `[8n+7:8n]` only; `sel`=0 completes with ack and no change.
- Input path: `gpio_in_i` -> sync1 -> sync2 (2-flop synchronizer) -> prev (1 more flop). IN reads sync2. Rising edge per bit = `sync2 & ~prev & EDGE_EN`.
- PENDING bit set on detected edge; cleared by writing 1 (selected lanes). Set and clear on the same cycle for the same bit -> set wins.
- `gpio_irq_o` <= `|(PENDING & IRQ_EN)` each cycle.
- `gpio_out_o` = OUT register directly.
- Reset: OUT, EDGE_EN, PENDING, IRQ_EN, sync1, sync2, prev = 0; `gpio_ack_o`, `gpio_err_o`, `gpio_irq_o`, `gpio_dat_o` = 0. A reset asserted mid-access drops any pending ack/err and performs no write; the master must restart the cycle.

## Timing
- Single-cycle registered termination: access accepted at edge k -> `ack_o`/`err_o` high for exactly one cycle after edge k; write takes effect at edge k; read data captured at edge k, valid only while ack high, 0 otherwise.
- Back-to-back: master holding `stb` after ack gets a new access accepted at edge k+2 (one idle cycle between terminations).
- Input latency: pin changes before edge k -> IN shows it after edge k+1; PENDING set after edge k+2; `gpio_irq_o` high after edge k+3.
- A write to IRQ_EN or PENDING at edge k is reflected on `gpio_irq_o` after edge k+1.
- Pulses shorter than one clock may be missed; no debouncing.

## Test plan
- Reset: hold `rst_i` 2 cycles with `gpio_in_i`=8'hFF -> `gpio_out_o`=0, `gpio_irq_o`=0, ack/err 0; read IN after 2 cycles -> 8'hFF.
- Write OUT=32'h0000_00A5 `sel`=4'b0001 -> one-cycle ack, `gpio_out_o`=8'hA5 next cycle; write 32'h0000_003C `sel`=4'b0000 -> ack, OUT stays 8'hA5; read OUT -> 32'h0000_00A5.
- EDGE_EN=8'h01, IRQ_EN=8'h01, toggle `gpio_in_i[0]` 0->1 -> PENDING=8'h01 after 3 edges, `gpio_irq_o`=1 one cycle later; write PENDING=1 -> `gpio_irq_o`=0 two cycles later; falling edge sets nothing.
- Rising edge on bit 0 detected in the same cycle as W1C of bit 0 -> PENDING[0] stays 1.
- Read address 0x14 and write to 0x04 -> `gpio_err_o` one cycle, no ack, `gpio_dat_o`=0, no register changed.
- Assert `rst_i` during the cycle a write to OUT is accepted -> no ack/err issued, OUT=0 after reset.

Source files
------------

// File: rtl/gpio.sv
// gpio: Wishbone B4 classic slave with general-purpose outputs, synchronized
// inputs and per-bit rising-edge interrupt capture.
//
// Register map (byte address bits [4:2], bits [1:0] ignored):
//   0 OUT     RW   drives gpio_out_o
//   1 IN      RO   synchronized gpio_in_i
//   2 EDGE_EN RW   per-bit rising-edge detect enable
//   3 PENDING RW1C captured edges
//   4 IRQ_EN  RW   per-bit interrupt enable
//   5..7      unmapped (error termination)
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   gpio_cyc_i/stb_i/we_i   bus cycle, slave strobe, write enable
//   gpio_sel_i              byte lane selects
//   gpio_adr_i              byte address
//   gpio_dat_i/gpio_dat_o   write / read data
//   gpio_ack_o/gpio_err_o   single-cycle registered terminations
//   gpio_in_i               asynchronous input pins
//   gpio_out_o              registered output pins
//   gpio_irq_o              registered level interrupt
module gpio #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADR_WIDTH = 32,
  parameter int unsigned DAT_WIDTH = 32,
  parameter int unsigned SEL_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 gpio_stb_i,
  input  logic                 gpio_cyc_i,
  input  logic                 gpio_we_i,
  input  logic [SEL_WIDTH-1:0] gpio_sel_i,
  input  logic [ADR_WIDTH-1:0] gpio_adr_i,
  input  logic [DAT_WIDTH-1:0] gpio_dat_i,
  output logic [DAT_WIDTH-1:0] gpio_dat_o,
  output logic                 gpio_ack_o,
  output logic                 gpio_err_o,
  input  logic [WIDTH-1:0]     gpio_in_i,
  output logic [WIDTH-1:0]     gpio_out_o,
  output logic                 gpio_irq_o
);

  typedef enum logic [2:0] {
    REG_OUT   = 3'd0,
    REG_IN    = 3'd1,
    REG_EDGE  = 3'd2,
    REG_PEND  = 3'd3,
    REG_IRQEN = 3'd4
  } reg_e;

  logic [WIDTH-1:0]     out_q, out_d;
  logic [WIDTH-1:0]     edge_q, edge_d;
  logic [WIDTH-1:0]     pend_q, pend_d;
  logic [WIDTH-1:0]     irqen_q, irqen_d;
  logic [WIDTH-1:0]     sync1_q, sync2_q, prev_q;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 irq_q, irq_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;

  logic [WIDTH-1:0]     wmask;
  logic [WIDTH-1:0]     wdata;
  logic [WIDTH-1:0]     clr;
  logic [WIDTH-1:0]     rise;
  logic [DAT_WIDTH-1:0] rdata;
  logic                 access;
  logic                 bad;
  reg_e                 idx;

  // Only adr[4:2], the low data bits and the low lanes are used.
  logic unused;
  assign unused = ^{gpio_adr_i, gpio_dat_i, gpio_sel_i};

  // Byte lane n gates bits [8n+7:8n].
  for (genvar b = 0; b < WIDTH; b++) begin : g_mask
    assign wmask[b] = gpio_sel_i[b/8];
  end

  assign wdata  = gpio_dat_i[WIDTH-1:0];
  assign idx    = reg_e'(gpio_adr_i[4:2]);
  assign access = gpio_cyc_i & gpio_stb_i & ~ack_q & ~err_q;
  assign bad    = (gpio_adr_i[4:2] > 3'd4) || (gpio_we_i && idx == REG_IN);
  assign rise   = sync2_q & ~prev_q & edge_q;

  always_comb begin
    rdata = '0;
    case (idx)
      REG_OUT:   rdata[WIDTH-1:0] = out_q;
      REG_IN:    rdata[WIDTH-1:0] = sync2_q;
      REG_EDGE:  rdata[WIDTH-1:0] = edge_q;
      REG_PEND:  rdata[WIDTH-1:0] = pend_q;
      REG_IRQEN: rdata[WIDTH-1:0] = irqen_q;
      default:   rdata = '0;
    endcase
  end

  always_comb begin
    out_d   = out_q;
    edge_d  = edge_q;
    irqen_d = irqen_q;
    clr     = '0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = '0;
    if (access) begin
      if (bad) begin
        err_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        if (gpio_we_i) begin
          case (idx)
            REG_OUT:   out_d   = (out_q & ~wmask) | (wdata & wmask);
            REG_EDGE:  edge_d  = (edge_q & ~wmask) | (wdata & wmask);
            REG_PEND:  clr     = wdata & wmask;
            REG_IRQEN: irqen_d = (irqen_q & ~wmask) | (wdata & wmask);
            default:   ;
          endcase
        end else begin
          dat_d = rdata;
        end
      end
    end
    // A new edge outranks a simultaneous W1C of the same bit.
    pend_d = (pend_q & ~clr) | rise;
    irq_d  = |(pend_q & irqen_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q   <= '0;
      edge_q  <= '0;
      pend_q  <= '0;
      irqen_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      out_q   <= out_d;
      edge_q  <= edge_d;
      pend_q  <= pend_d;
      irqen_q <= irqen_d;
      sync1_q <= gpio_in_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      ack_q   <= ack_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
      dat_q   <= dat_d;
    end
  end

  assign gpio_dat_o = dat_q;
  assign gpio_ack_o = ack_q;
  assign gpio_err_o = err_q;
  assign gpio_out_o = out_q;
  assign gpio_irq_o = irq_q;

endmodule
